// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI register-protocol master: word geometry,
// header layout, FSM state encoding and the word-sequencing helper.
package spi_master_ctrl_pkg;

    localparam int SPI_WORD_W = 16;
    localparam int SPI_MSB = SPI_WORD_W - 1;
    localparam int SPI_RW_BIT = 15;
    localparam logic SPI_RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_LO        = 3'd2,
        ST_HI        = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_HOLD      = 3'd5,
        ST_GAP       = 3'd6
    } state_t;

    // word_idx is the index of the word just finished (0 = header).
    // A frame carries len+2 words in total, so another word follows
    // while word_idx <= len.
    function automatic logic more_words(input logic [8:0] word_idx,
                                        input logic [7:0] len);
        return word_idx <= {1'b0, len};
    endfunction

endpackage

// File: rtl/spi_master_ctrl_half_tick.sv
// Phase timer: down-counter of DIV cycles, reloaded whenever the owning FSM
// changes state, so every timed state lasts exactly DIV cycles. tick marks
// the final cycle of the period.
module spi_master_ctrl_half_tick #(
    parameter int DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on restart or at period end, otherwise count down.
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (restart || cnt_q == '0) begin
            cnt_d = RELOAD;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master for the 16-bit register protocol: CS low, header {rw,addr},
// len+1 data words MSB first, CS high, then an idle gap. SPI mode 0.
// Build option SPI_MASTER_LOOPBACK_EN adds loopback_i, which feeds MOSI back
// into the MISO sampler for self-test.
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [14:0]           cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  wr_data_valid,
    output logic                  wr_data_ready,
    input  logic [SPI_WORD_W-1:0] wr_data,
    output logic                  rd_data_valid,
    output logic [SPI_WORD_W-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  spi_cs,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic                  loopback_i,
`endif
    input  logic                  spi_miso
);

    state_t                state_q, state_d;
    logic                  rw_q, rw_d;
    logic [7:0]            len_q, len_d;
    logic [SPI_WORD_W-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_WORD_W-1:0] rx_shift_q, rx_shift_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [8:0]            word_cnt_q, word_cnt_d;
    logic                  first_q, first_d;
    logic                  cs_q, cs_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [SPI_WORD_W-1:0] rd_data_q, rd_data_d;

    logic restart;
    logic half_tick;
    logic gap_tick;
    logic miso_in;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign miso_in = loopback_i ? mosi_q : spi_miso;
`else
    assign miso_in = spi_miso;
`endif

    // Any state change restarts both phase timers.
    assign restart = (state_d != state_q);

    spi_master_ctrl_half_tick #(.DIV(CLK_DIV)) u_half_tick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .restart (restart),
        .tick    (half_tick)
    );

    spi_master_ctrl_half_tick #(.DIV(CS_IDLE)) u_gap_tick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .restart (restart),
        .tick    (gap_tick)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        len_d      = len_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rw_d       = cmd_rw;
                    len_d      = cmd_len;
                    tx_shift_d = {cmd_rw, cmd_addr};
                    mosi_d     = tx_shift_d[SPI_RW_BIT];
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    cs_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (half_tick) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (half_tick) begin
                    sclk_d  = 1'b1;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                // First cycle after the rising edge: capture MISO.
                if (first_q) begin
                    rx_shift_d = {rx_shift_q[SPI_MSB-1:0], miso_in};
                    bit_cnt_d  = bit_cnt_q + 5'd1;
                end
                if (half_tick) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == 5'(SPI_WORD_W)) begin
                        bit_cnt_d  = '0;
                        word_cnt_d = word_cnt_q + 9'd1;
                        if (rw_q != SPI_RW_WRITE && word_cnt_q != '0) begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = rx_shift_q;
                        end
                        if (more_words(word_cnt_q, len_q)) begin
                            if (rw_q == SPI_RW_WRITE) begin
                                if (wr_data_valid) begin
                                    tx_shift_d = wr_data;
                                    mosi_d     = wr_data[SPI_MSB];
                                    wr_ready_d = 1'b1;
                                    state_d    = ST_LO;
                                end else begin
                                    state_d = ST_WAIT_DATA;
                                end
                            end else begin
                                tx_shift_d = '0;
                                mosi_d     = 1'b0;
                                state_d    = ST_LO;
                            end
                        end else begin
                            mosi_d  = 1'b0;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        tx_shift_d = {tx_shift_q[SPI_MSB-1:0], 1'b0};
                        mosi_d     = tx_shift_q[SPI_MSB-1];
                        state_d    = ST_LO;
                    end
                end
            end
            ST_WAIT_DATA: begin
                // SCLK parked low, CS held low until the host supplies a word.
                if (wr_data_valid) begin
                    tx_shift_d = wr_data;
                    mosi_d     = wr_data[SPI_MSB];
                    wr_ready_d = 1'b1;
                    state_d    = ST_LO;
                end
            end
            ST_HOLD: begin
                if (half_tick) begin
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_tick) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        first_d     = restart;
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            rw_q        <= 1'b0;
            len_q       <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            first_q     <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            len_q       <= len_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            first_q     <= first_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign wr_data_ready = wr_ready_q;
    assign rd_data_valid = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign spi_cs        = cs_q;
    assign spi_sclk      = sclk_q;
    assign spi_mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a behavioural SPI register slave, a host-side
// write-data feeder with programmable post-header stall, and frame-level
// expectations from a reference register array.
module tb_spi_master_ctrl;

    localparam int CLK_DIV = 4;
    localparam int CS_IDLE = 4;
    localparam int MEM = 1024;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rw = 1'b0;
    logic [14:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_data_valid;
    logic        wr_data_ready;
    logic [15:0] wr_data;
    logic        rd_data_valid;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        spi_cs;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic        loopback_i = 1'b0;
`endif

    // Counters.
    int n_checks = 0;
    int n_pass = 0;

    // Slave / monitor state (owned by the negedge process).
    logic [15:0] slave_mem [0:MEM-1] = '{default: 16'h0};
    logic [15:0] s_shift = '0;
    logic        s_rw = 1'b0;
    logic [14:0] s_addr = '0;
    int s_rise = 0, s_fall = 0, widx = 0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0;
    int done_cnt = 0, done_viol = 0, rdy_viol = 0;
    int stall_cnt = 0, stall_seen = 0, stall_viol = 0;
    int cs_high_run = 0, min_cs_high = 1000000;
    logic [15:0] rd_buf [0:4095];
    int rd_wr_idx = 0;
    int wr_rd_idx = 0;

    // Host-side state (owned by the main initial block).
    logic [15:0] ref_mem [0:MEM-1] = '{default: 16'h0};
    logic [15:0] wr_buf [0:4095] = '{default: 16'h0};
    int wr_wr_idx = 0;
    int stall_req = 0;
    int rd_rd_idx = 0;
    logic [15:0] exp_q [$];
    logic [15:0] fixed_w [0:3];
    int fixed_n = 0;

    assign wr_data_valid = (wr_rd_idx != wr_wr_idx) && (stall_cnt >= stall_req);
    assign wr_data       = wr_buf[wr_rd_idx % 4096];

    spi_master_ctrl #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .wr_data       (wr_data),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .spi_cs        (spi_cs),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback_i    (loopback_i),
`endif
        .spi_miso      (spi_miso)
    );

    always #5 clk_i = ~clk_i;

    // Slave model, write-data feeder and protocol monitors, all sampled
    // mid-cycle on the falling clock edge.
    always @(negedge clk_i) begin
        if (prev_cs && !spi_cs) begin
            s_rise = 0;
            s_fall = 0;
        end
        if (!spi_cs && spi_sclk && !prev_sclk) begin
            s_shift = {s_shift[14:0], spi_mosi};
            s_rise++;
            if (s_rise == 16) begin
                s_rw   = s_shift[15];
                s_addr = s_shift[14:0];
            end else if (s_rise % 16 == 0 && s_rw) begin
                widx = (int'(s_addr) + s_rise / 16 - 2) % MEM;
                slave_mem[widx] = s_shift;
            end
        end
        if (!spi_cs && !spi_sclk && prev_sclk) begin
            s_fall++;
            if (s_fall >= 16 && !s_rw) begin
                widx = (int'(s_addr) + s_fall / 16 - 1) % MEM;
                spi_miso = slave_mem[widx][15 - (s_fall % 16)];
            end else begin
                spi_miso = 1'($urandom_range(0, 1));
            end
        end
        // Post-header stall window for the write-data feeder.
        if (spi_cs || s_fall < 16) begin
            stall_cnt = 0;
        end else if (stall_cnt < stall_req) begin
            stall_cnt++;
            stall_seen++;
            if (spi_sclk || spi_cs) stall_viol++;
        end
        if (wr_data_ready) wr_rd_idx++;
        if (rd_data_valid) begin
            rd_buf[rd_wr_idx % 4096] = rd_data;
            rd_wr_idx++;
        end
        if (done) begin
            done_cnt++;
            if (!(spi_cs && !prev_cs)) done_viol++;
        end
        if (cmd_ready && (busy || !spi_cs)) rdy_viol++;
        if (spi_cs) begin
            cs_high_run++;
        end else begin
            if (prev_cs && cs_high_run < min_cs_high) min_cs_high = cs_high_run;
            cs_high_run = 0;
        end
        prev_cs   = spi_cs;
        prev_sclk = spi_sclk;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present a command and return on the negedge after it was accepted.
    task automatic issue_cmd(input logic rw, input logic [14:0] addr, input logic [7:0] len);
        int t;
        cmd_rw = rw;
        cmd_addr = addr;
        cmd_len = len;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 2000) check_value("cmd_accept_timeout", 32'(t), 32'd0);
        @(negedge clk_i);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 20000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 20000) check_value("busy_timeout", 32'(t), 32'd0);
    endtask

    task automatic check_reads();
        logic [15:0] e;
        check_value("rd_count", 32'(rd_wr_idx - rd_rd_idx), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_rd_idx < rd_wr_idx) begin
                check_value("rd_data", 32'(rd_buf[rd_rd_idx % 4096]), 32'(e));
                rd_rd_idx++;
            end
        end
        rd_rd_idx = rd_wr_idx;
    endtask

    // Queue the host side of one frame and record what the slave must see.
    task automatic stage_frame(input logic rw, input logic [14:0] addr, input logic [7:0] len, input bit lb);
        logic [15:0] w;
        for (int k = 0; k <= int'(len); k++) begin
            if (rw) begin
                w = (k < fixed_n) ? fixed_w[k] : 16'($urandom);
                wr_buf[wr_wr_idx % 4096] = w;
                wr_wr_idx++;
                ref_mem[(int'(addr) + k) % MEM] = w;
            end else begin
                exp_q.push_back(lb ? 16'h0000 : ref_mem[(int'(addr) + k) % MEM]);
            end
        end
        fixed_n = 0;
    endtask

    task automatic run_frame(input logic rw, input logic [14:0] addr, input logic [7:0] len,
                             input int stall, input bit lb);
        int done0;
        done0 = done_cnt;
        stall_req = stall;
        stage_frame(rw, addr, len, lb);
        issue_cmd(rw, addr, len);
        cmd_valid = 1'b0;
        wait_idle();
        $display("frame rw=%0d addr=0x%03h len=%0d stall=%0d rises=%0d", rw, addr, len, stall, s_rise);
        check_value("done_count", 32'(done_cnt - done0), 32'd1);
        check_value("sclk_rises", 32'(s_rise), 32'(16 * (int'(len) + 2)));
        if (rw) begin
            check_value("wr_consumed", 32'(wr_rd_idx), 32'(wr_wr_idx));
            for (int k = 0; k <= int'(len); k++)
                check_value("slave_reg", 32'(slave_mem[(int'(addr) + k) % MEM]),
                            32'(ref_mem[(int'(addr) + k) % MEM]));
        end
        check_reads();
        stall_req = 0;
    endtask

    initial begin
        int done0, seen0, t;
        logic [15:0] w0;
        logic [14:0] a;
        logic [7:0]  l;
        logic        r;

        // Reset state.
        repeat (3) @(negedge clk_i);
        check_value("rst_cs", 32'(spi_cs), 32'd1);
        check_value("rst_sclk", 32'(spi_sclk), 32'd0);
        check_value("rst_mosi", 32'(spi_mosi), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_wr_ready", 32'(wr_data_ready), 32'd0);
        check_value("rst_rd_valid", 32'(rd_data_valid), 32'd0);
        check_value("rst_rd_data", 32'(rd_data), 32'd0);
        reset_i = 1'b0;
        @(negedge clk_i);
        check_value("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Directed write of three words to 0x10.
        fixed_w[0] = 16'h1111; fixed_w[1] = 16'h2222; fixed_w[2] = 16'h3333; fixed_n = 3;
        run_frame(1'b1, 15'h0010, 8'd2, 0, 1'b0);
        check_value("reg_0x12", 32'(slave_mem[16'h12]), 32'h3333);

        // Directed read-back of two known registers.
        fixed_w[0] = 16'hA5A5; fixed_w[1] = 16'h5A5A; fixed_n = 2;
        run_frame(1'b1, 15'h0020, 8'd1, 0, 1'b0);
        run_frame(1'b0, 15'h0020, 8'd1, 0, 1'b0);

        // Write stalled 50 cycles after the header.
        seen0 = stall_seen;
        run_frame(1'b1, 15'h0040, 8'd3, 50, 1'b0);
        check_value("stall_cycles", 32'(stall_seen - seen0), 32'd50);
        check_value("stall_bus_idle", 32'(stall_viol), 32'd0);

        // Back-to-back reads with cmd_valid held high throughout.
        done0 = done_cnt;
        for (int f = 0; f < 3; f++) begin
            a = 15'(16 + 8 * f);
            l = 8'(f);
            stage_frame(1'b0, a, l, 1'b0);
            issue_cmd(1'b0, a, l);
        end
        cmd_valid = 1'b0;
        wait_idle();
        $display("back-to-back 3 reads done=%0d", done_cnt - done0);
        check_value("b2b_done", 32'(done_cnt - done0), 32'd3);
        check_reads();

        // Reset in the middle of the second data word of a write.
        done0 = done_cnt;
        fixed_n = 0;
        stage_frame(1'b1, 15'h0100, 8'd3, 1'b0);
        w0 = wr_buf[(wr_wr_idx - 4) % 4096];
        for (int k = 1; k <= 3; k++) ref_mem[16'h100 + k] = slave_mem[16'h100 + k];
        issue_cmd(1'b1, 15'h0100, 8'd3);
        cmd_valid = 1'b0;
        @(negedge clk_i);
        t = 0;
        while (s_rise < 40 && t < 5000) begin
            @(negedge clk_i);
            t++;
        end
        check_value("mid_frame_reach", 32'(t < 5000), 32'd1);
        reset_i = 1'b1;
        @(negedge clk_i);
        check_value("midrst_cs", 32'(spi_cs), 32'd1);
        check_value("midrst_sclk", 32'(spi_sclk), 32'd0);
        reset_i = 1'b0;
        wr_wr_idx = wr_rd_idx;
        repeat (10) @(negedge clk_i);
        $display("mid-frame reset at rise 40");
        check_value("midrst_no_done", 32'(done_cnt - done0), 32'd0);
        check_value("midrst_word1", 32'(slave_mem[16'h100]), 32'(w0));
        check_value("midrst_word2", 32'(slave_mem[16'h101]), 32'(ref_mem[16'h101]));
        ref_mem[16'h100] = w0;
        run_frame(1'b1, 15'h0100, 8'd3, 0, 1'b0);

        // Randomised frames against the reference register array.
        for (int i = 0; i < 16; i++) begin
            r = 1'($urandom_range(0, 1));
            a = 15'($urandom_range(0, 800));
            l = 8'($urandom_range(0, 12));
            run_frame(r, a, l, r ? int'($urandom_range(0, 30)) : 0, 1'b0);
        end

`ifdef SPI_MASTER_LOOPBACK_EN
        // Loopback: data words read back the all-zero MOSI pattern.
        loopback_i = 1'b1;
        run_frame(1'b0, 15'h0010, 8'd2, 0, 1'b1);
        loopback_i = 1'b0;
`endif

        check_value("cmd_ready_only_idle", 32'(rdy_viol), 32'd0);
        check_value("done_on_cs_rise", 32'(done_viol), 32'd0);
        check_value("cs_idle_min_ok", 32'(min_cs_high >= CS_IDLE), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
